cpu_req_gen: RTL and testbench

Synthesizable CPU-side request sequencer that drives the cache's CPU port (`cpu_req` / `cpu_res`, types from `cache_def`). It is the initiator end of the interface served by `dm_cache_fsm`. On `start` it writes a deterministic pattern to `NUM_REQ` word addresses, then reads each one back and compares it against the expected value. It reports the pass count, the mismatch count and completion, and is instantiated in `top` in place of the testcase's CPU driver for self-checking runs.

---
 rtl/cpu_req_gen.sv | 207 ++++++++++++++++++++
 tb/tb_cpu_req_gen.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_req_gen.sv
// cpu_req_gen: writes a deterministic pattern through the cache CPU port, reads it back and counts matches.
// Optional ready watchdog is enabled by defining CPU_REQ_GEN_TIMEOUT_EN.
package cache_def;
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        rw;
        logic        valid;
    } cpu_req_type;

    typedef struct packed {
        logic [31:0] data;
        logic        ready;
    } cpu_result_type;
endpackage

module cpu_req_gen #(
    parameter int unsigned NUM_REQ   = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] STRIDE    = 32'd4,
    parameter logic [31:0] SEED      = 32'hA5A5_0000
`ifdef CPU_REQ_GEN_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT   = 255
`endif
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output cache_def::cpu_req_type   cpu_req,
    input  cache_def::cpu_result_type cpu_res,
    output logic                     busy,
    output logic                     done,
    output logic [15:0]              pass_cnt,
    output logic [15:0]              err_cnt,
    output logic                     timeout
);

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_GAP, RD_REQ, RD_GAP, DONE} state_t;

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    state_t            r_state, w_stateNext;
    logic [IDX_W-1:0]  r_idx, w_idxNext;
    logic [31:0]       r_addr, w_addrNext, w_addrInc;
    logic [31:0]       r_data, w_dataNext;
    logic              r_rw, w_rwNext;
    logic              r_valid, w_validNext;
    logic              r_cmpPend, r_cmpOk;
    logic [15:0]       r_passCnt, r_errCnt;
    logic              w_handshake, w_startRun, w_last, w_tmo;

    assign w_handshake = r_valid & cpu_res.ready;
    assign w_startRun  = start & ((r_state == IDLE) | (r_state == DONE));
    assign w_last      = (r_idx == LAST_IDX);
    assign w_addrInc   = r_addr + STRIDE;

`ifdef CPU_REQ_GEN_TIMEOUT_EN
    logic [31:0] r_waitCnt;
    logic        r_timeout;

    assign w_tmo = r_valid & ~cpu_res.ready & (r_waitCnt == TIMEOUT - 1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_waitCnt <= '0;
            r_timeout <= 1'b0;
        end else if (w_startRun) begin
            r_waitCnt <= '0;
            r_timeout <= 1'b0;
        end else if (r_valid) begin
            if (cpu_res.ready) begin
                r_waitCnt <= '0;
            end else begin
                r_waitCnt <= r_waitCnt + 32'd1;
                if (w_tmo) r_timeout <= 1'b1;
            end
        end
    end

    assign timeout = r_timeout;
`else
    assign w_tmo   = 1'b0;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_stateNext;
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE, DONE: if (start) w_stateNext = WR_REQ;
            WR_REQ:     if (w_tmo) w_stateNext = DONE;
                        else if (w_handshake) w_stateNext = WR_GAP;
            WR_GAP:     w_stateNext = w_last ? RD_REQ : WR_REQ;
            RD_REQ:     if (w_tmo) w_stateNext = DONE;
                        else if (w_handshake) w_stateNext = RD_GAP;
            RD_GAP:     w_stateNext = w_last ? DONE : RD_REQ;
            default:    w_stateNext = IDLE;
        endcase
    end

    // Request fields are prepared one state ahead so valid rises only once the REQ state is entered.
    always_comb begin
        w_idxNext   = r_idx;
        w_addrNext  = r_addr;
        w_dataNext  = r_data;
        w_rwNext    = r_rw;
        w_validNext = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                done = (r_state == DONE);
                if (start) begin
                    w_idxNext  = '0;
                    w_addrNext = BASE_ADDR;
                    w_dataNext = BASE_ADDR ^ SEED;
                    w_rwNext   = 1'b1;
                end
            end
            WR_REQ, RD_REQ: begin
                busy        = 1'b1;
                w_validNext = ~w_handshake & ~w_tmo;
            end
            WR_GAP: begin
                busy        = 1'b1;
                w_validNext = 1'b1;
                if (w_last) begin
                    w_idxNext  = '0;
                    w_addrNext = BASE_ADDR;
                    w_dataNext = '0;
                    w_rwNext   = 1'b0;
                end else begin
                    w_idxNext  = r_idx + IDX_W'(1);
                    w_addrNext = w_addrInc;
                    w_dataNext = w_addrInc ^ SEED;
                    w_rwNext   = 1'b1;
                end
            end
            RD_GAP: begin
                busy = 1'b1;
                if (!w_last) begin
                    w_validNext = 1'b1;
                    w_idxNext   = r_idx + IDX_W'(1);
                    w_addrNext  = w_addrInc;
                    w_dataNext  = '0;
                    w_rwNext    = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx   <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_rw    <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_idx   <= w_idxNext;
            r_addr  <= w_addrNext;
            r_data  <= w_dataNext;
            r_rw    <= w_rwNext;
            r_valid <= w_validNext;
        end
    end

    // Read data is judged at the handshake edge; the counters follow one edge later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cmpPend <= 1'b0;
            r_cmpOk   <= 1'b0;
            r_passCnt <= '0;
            r_errCnt  <= '0;
        end else if (w_startRun) begin
            r_cmpPend <= 1'b0;
            r_cmpOk   <= 1'b0;
            r_passCnt <= '0;
            r_errCnt  <= '0;
        end else begin
            r_cmpPend <= w_handshake & ~r_rw;
            if (w_handshake) r_cmpOk <= (cpu_res.data == (r_addr ^ SEED));
            if (r_cmpPend) begin
                if (r_cmpOk)                  r_passCnt <= r_passCnt + 16'd1;
                else if (r_errCnt != 16'hFFFF) r_errCnt  <= r_errCnt + 16'd1;
            end
        end
    end

    always_comb begin
        cpu_req.addr  = r_addr;
        cpu_req.data  = r_data;
        cpu_req.rw    = r_rw;
        cpu_req.valid = r_valid;
    end

    assign pass_cnt = r_passCnt;
    assign err_cnt  = r_errCnt;

endmodule

// File: tb/tb_cpu_req_gen.sv
// Self-checking bench for cpu_req_gen: ideal cache model with wait states, corruption and stalls,
// a request scoreboard, and a table of full runs plus hand-written reset/restart/stall sequences.
module tb_cpu_req_gen;
    import cache_def::*;

    localparam int unsigned NREQ = 4;
    localparam logic [31:0] BASE = 32'h0000_0100;
    localparam logic [31:0] STEP = 32'd4;
    localparam logic [31:0] KEY  = 32'hA5A5_0000;
`ifdef CPU_REQ_GEN_TIMEOUT_EN
    localparam int TMO = 10;
`endif

    typedef struct {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    typedef struct {
        int         waitCycles;
        logic [3:0] corruptMask;
        int         expPass;
        int         expErr;
        int         expCycles;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    cpu_req_type    cpuReq;
    cpu_result_type cpuRes = '0;
    logic           busy, done, timeout;
    logic [15:0]    passCnt, errCnt;

    int             errors = 0;
    int             checks = 0;
    int             cycleCnt = 0;

    int             waitCycles = 0;
    int             waitCnt = 0;
    logic [3:0]     corruptMask = '0;
    logic           stallEn = 1'b0;
    logic           stallRw = 1'b0;
    logic [31:0]    stallAddr = '0;
    logic [31:0]    mem [0:255];
    txn_t           sbQueue[$];
    vec_t           vecs[4];

    cpu_req_gen #(
        .NUM_REQ  (NREQ),
        .BASE_ADDR(BASE),
        .STRIDE   (STEP),
        .SEED     (KEY)
`ifdef CPU_REQ_GEN_TIMEOUT_EN
        ,
        .TIMEOUT  (TMO)
`endif
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .cpu_req (cpuReq),
        .cpu_res (cpuRes),
        .busy    (busy),
        .done    (done),
        .pass_cnt(passCnt),
        .err_cnt (errCnt),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt++;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Cache model: decides ready at the falling edge so the handshake lands on the next rising edge.
    always @(negedge clk) begin
        txn_t exp;
        int   idx;
        cpuRes.ready = 1'b0;
        if (rst && cpuReq.valid) begin
            if (stallEn && cpuReq.rw == stallRw && cpuReq.addr == stallAddr) begin
                waitCnt = 0;
            end else if (waitCnt < waitCycles) begin
                waitCnt++;
            end else begin
                cpuRes.ready = 1'b1;
                if (sbQueue.size() == 0) begin
                    checkOutput("sb_unexpected_req", cpuReq.addr, 32'hFFFF_FFFF);
                end else begin
                    exp = sbQueue.pop_front();
                    checkOutput("sb_rw", {31'd0, cpuReq.rw}, {31'd0, exp.rw});
                    checkOutput("sb_addr", cpuReq.addr, exp.addr);
                    checkOutput("sb_data", cpuReq.data, exp.data);
                end
                if (cpuReq.rw) begin
                    mem[cpuReq.addr[9:2]] = cpuReq.data;
                end else begin
                    idx = int'((cpuReq.addr - BASE) >> 2);
                    cpuRes.data = mem[cpuReq.addr[9:2]];
                    if (idx < 4 && corruptMask[idx]) cpuRes.data = cpuRes.data ^ 32'd1;
                end
            end
        end else begin
            waitCnt = 0;
        end
    end

    task automatic applyStimulus(output int tStart);
        logic [31:0] a;
        @(negedge clk); #1;
        start = 1'b1;
        tStart = cycleCnt;
        for (int i = 0; i < int'(NREQ); i++) begin
            a = BASE + STEP * i;
            sbQueue.push_back('{1'b1, a, a ^ KEY});
        end
        for (int i = 0; i < int'(NREQ); i++) begin
            a = BASE + STEP * i;
            sbQueue.push_back('{1'b0, a, 32'd0});
        end
        @(negedge clk); #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input int limit);
        int n = 0;
        while (!done && n < limit) begin
            @(negedge clk); #1;
            n++;
        end
    endtask

    task automatic runVector(input vec_t v, input string tag);
        int tStart, tValid, n;
        waitCycles  = v.waitCycles;
        corruptMask = v.corruptMask;
        applyStimulus(tStart);
        checkOutput({tag, "_busy_after_start"}, {31'd0, busy}, 32'd1);
        checkOutput({tag, "_cnt_cleared"}, {passCnt, errCnt}, 32'd0);
        checkOutput({tag, "_done_cleared"}, {31'd0, done}, 32'd0);
        n = 0;
        while (!cpuReq.valid && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        checkOutput({tag, "_start_to_valid"}, cycleCnt - tStart, 32'd2);
        tValid = cycleCnt;
        waitDone(2000);
        checkOutput({tag, "_cycles"}, cycleCnt - tValid, v.expCycles);
        checkOutput({tag, "_pass_cnt"}, {16'd0, passCnt}, v.expPass);
        checkOutput({tag, "_err_cnt"}, {16'd0, errCnt}, v.expErr);
        checkOutput({tag, "_done"}, {31'd0, done}, 32'd1);
        checkOutput({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
        checkOutput({tag, "_valid_end"}, {31'd0, cpuReq.valid}, 32'd0);
        checkOutput({tag, "_timeout"}, {31'd0, timeout}, 32'd0);
        checkOutput({tag, "_sb_left"}, sbQueue.size(), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL global_watchdog: got running, expected finished");
        $fatal(1, "[TB] simulation watchdog expired");
    end

    initial begin
        int tStart, n, high;
        vec_t clean;

        vecs[0] = '{0, 4'b0000, 4, 0, 16};
        vecs[1] = '{0, 4'b0100, 3, 1, 16};
        vecs[2] = '{2, 4'b0000, 4, 0, 32};
        vecs[3] = '{1, 4'b1001, 2, 2, 24};
        clean   = vecs[0];

        #12;
        checkOutput("reset_outputs", {cpuReq.addr | cpuReq.data, 14'd0, cpuReq.rw, cpuReq.valid,
                    busy, done, timeout}, 32'd0);
        checkOutput("reset_counters", {passCnt, errCnt}, 32'd0);
        @(negedge clk); #1;
        rst = 1'b1;

        foreach (vecs[k]) runVector(vecs[k], $sformatf("vec%0d", k));

        // start pulsed while busy, in a cycle where ready is also high
        waitCycles = 0;
        corruptMask = '0;
        applyStimulus(tStart);
        n = 0;
        while (!(cpuReq.valid && !cpuReq.rw && cpuReq.addr == BASE + 8 && cpuRes.ready) && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        checkOutput("busy_start_pass_kept", {16'd0, passCnt}, 32'd2);
        checkOutput("busy_start_still_busy", {31'd0, busy}, 32'd1);
        waitDone(200);
        checkOutput("busy_start_pass_final", {16'd0, passCnt}, 32'd4);
        checkOutput("busy_start_err_final", {16'd0, errCnt}, 32'd0);
        checkOutput("busy_start_sb_left", sbQueue.size(), 32'd0);

        // reset mid-way through read 2 while ready is held low
        stallEn = 1'b1;
        stallRw = 1'b0;
        stallAddr = BASE + 8;
        applyStimulus(tStart);
        n = 0;
        while (!(cpuReq.valid && !cpuReq.rw && cpuReq.addr == BASE + 8) && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        repeat (3) @(negedge clk);
        #1;
        checkOutput("stall_rd_valid_held", {31'd0, cpuReq.valid}, 32'd1);
        checkOutput("stall_rd_pass_before", {16'd0, passCnt}, 32'd2);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_rst_valid", {31'd0, cpuReq.valid}, 32'd0);
        checkOutput("async_rst_counters", {passCnt, errCnt}, 32'd0);
        checkOutput("async_rst_busy_done", {30'd0, busy, done}, 32'd0);
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b1;
        stallEn = 1'b0;
        sbQueue.delete();
        repeat (3) @(negedge clk);
        #1;
        checkOutput("post_rst_idle", {30'd0, busy, cpuReq.valid}, 32'd0);
        runVector(clean, "after_rst");

        // write 0 never acknowledged
        stallEn = 1'b1;
        stallRw = 1'b1;
        stallAddr = BASE;
        applyStimulus(tStart);
        high = 0;
`ifdef CPU_REQ_GEN_TIMEOUT_EN
        n = 0;
        do begin
            @(negedge clk); #1;
            if (cpuReq.valid) high++;
            n++;
        end while ((cpuReq.valid || n < 3) && n < 300);
        checkOutput("tmo_valid_cycles", high, TMO);
        checkOutput("tmo_flag", {31'd0, timeout}, 32'd1);
        checkOutput("tmo_done", {31'd0, done}, 32'd1);
        checkOutput("tmo_busy", {31'd0, busy}, 32'd0);
        checkOutput("tmo_pass", {16'd0, passCnt}, 32'd0);
`else
        for (int k = 0; k < 300; k++) begin
            @(negedge clk); #1;
            if (cpuReq.valid) high++;
        end
        checkOutput("stall_valid_cycles", high, 32'd300);
        checkOutput("stall_timeout_low", {31'd0, timeout}, 32'd0);
        checkOutput("stall_busy", {31'd0, busy}, 32'd1);
        checkOutput("stall_done_low", {31'd0, done}, 32'd0);
`endif
        rst = 1'b0;
        stallEn = 1'b0;
        sbQueue.delete();
        @(negedge clk); #1;
        checkOutput("final_rst_valid", {31'd0, cpuReq.valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
